bram_cfg_agu: RTL and testbench
===============================

Name: bram_cfg_agu

Overview:
- Downstream consumer of the interface controller's BRAM configuration token stream.
- Collects three configuration words (base, length, stride) and waits for the start request.
- Then issues a strided BRAM address sequence under stall backpressure.
- When the sequence finishes, it returns a one-cycle completion pulse that drives the controller's Done input.

Parameters:
WIDTH_ADDR, 12, BRAM address width; address arithmetic is modulo 2^WIDTH_ADDR.
WIDTH_LEN, 12, width of the access-count field and the remaining-count register.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
I_RCFG  in  FTk_t  configuration token from the interface controller; only .v and .d are used.
I_Start  in  1  run request (controller Req); sampled only in WAIT.
I_Abort  in  1  release/abort; forces IDLE from any state.
I_Stall  in  1  BRAM backpressure; an address beat is accepted only when low.
O_Addr  out  WIDTH_ADDR  current BRAM address (registered).
O_Addr_v  out  1  address valid.
O_Last  out  1  marks the final address beat.
O_Done  out  1  one-cycle completion pulse.
O_Busy  out  1  high whenever FSM != IDLE.
O_Err  out  1  one-cycle pulse when a configuration word arrives outside IDLE/CFG.

Behaviour:
- Reset (reset==0, asynchronous):
  - FSM=IDLE; BASE, LEN, STRIDE, O_Addr, remaining count and word index all 0.
  - Every output is 0 immediately; reset is released synchronously.
- Word acceptance: one configuration word is accepted on every clock edge where I_RCFG.v=1 in IDLE or CFG. There is no edge detection; the producer presents each word for exactly one valid cycle.
- FSM states: IDLE, CFG, WAIT, GEN, DONE.
- IDLE:
  - On I_RCFG.v: BASE <= d[WIDTH_ADDR-1:0], word index <= 1, go to CFG.
- CFG:
  - Index 1 with v: LEN <= d[WIDTH_LEN-1:0], index <= 2.
  - Index 2 with v: STRIDE <= d[WIDTH_ADDR-1:0], go to WAIT.
  - Cycles with v=0 hold state.
- WAIT:
  - On I_Start: O_Addr <= BASE, remaining <= LEN.
  - Next state is DONE if LEN==0, otherwise GEN.
  - Latency: I_Start sampled at edge t; O_Addr_v=1 with O_Addr=BASE from cycle t+1.
- GEN:
  - O_Addr_v=1 in every GEN cycle, including stalled cycles; address and count hold while I_Stall=1.
  - A beat is accepted on an edge with I_Stall=0: O_Addr <= O_Addr+STRIDE (wraps silently), remaining <= remaining-1.
  - O_Last = (remaining==1), combinational from registers.
  - Once the beat with remaining==1 is accepted, go to DONE.
- DONE:
  - O_Done=1 for exactly one cycle; O_Addr_v=0; next state IDLE.
  - Configuration registers keep their values, but a new configuration always starts from BASE.
- I_Abort:
  - Highest priority in every state: next state IDLE, word index 0, O_Addr_v drops next cycle.
  - No O_Done, no O_Err.
  - I_Abort simultaneous with the final beat also gives IDLE without O_Done.
- Error:
  - I_RCFG.v in WAIT, GEN or DONE pulses O_Err for one cycle.
  - The word is discarded; state, address and count are unaffected.
- Simultaneous events:
  - I_Start in any state other than WAIT is ignored.
  - I_Start together with I_RCFG.v in WAIT starts the sequence and also pulses O_Err.
- Stride 0 is legal and repeats BASE LEN times.
- LEN is unsigned; the maximum is 2^WIDTH_LEN-1.

Decomposition:
- Add to pkg_bram_if:
  - enum fsm_bram_agu {AGU_IDLE, AGU_CFG, AGU_WAIT, AGU_GEN, AGU_DONE}.
  - localparams AGU_IDX_BASE=0, AGU_IDX_LEN=1, AGU_IDX_STRIDE=2.
- FTk_t and WIDTH_DATA come from pkg_en.
- One sub-module, agu_step, holds the address/remaining registers. Inputs: load, step, base, len, stride. Outputs: addr, remaining, last.

Test Plan:
1. Words 0x010, 4, 3, then I_Start, I_Stall=0 -> O_Addr_v for 4 cycles with O_Addr 0x010, 0x013, 0x016, 0x019; O_Last on the 4th beat only; O_Done pulses the next cycle; O_Busy falls after it.
2. Same configuration with I_Stall=1 for 3 cycles on beat 2 -> O_Addr holds 0x013 with O_Addr_v=1 for 4 cycles; sequence and O_Done otherwise unchanged.
3. Words 0xFFE, 3, 1 -> addresses 0xFFE, 0xFFF, 0x000; O_Last on 0x000.
4. LEN=0, I_Start -> O_Addr_v never set; O_Done high on the cycle after the I_Start edge.
5. I_Abort during beat 2 of scenario 1 -> IDLE next cycle, O_Addr_v=0, no O_Done. A subsequent configuration 0x020, 2, 8 yields 0x020, 0x028.
6. Word with v=1 during GEN -> single O_Err pulse, address sequence identical to scenario 1. Asserting reset=0 mid-GEN clears all outputs without waiting for a clock edge.

Source files
------------

// File: rtl/bram_cfg_agu_pkg.sv
// Shared types for the BRAM configuration address generator:
// configuration token format, FSM encoding and word-slot indices.
package bram_cfg_agu_pkg;

  localparam int unsigned WIDTH_DATA = 16;

  typedef struct packed {
    logic                  v;
    logic [WIDTH_DATA-1:0] d;
  } FTk_t;

  typedef enum logic [2:0] {
    AGU_IDLE,
    AGU_CFG,
    AGU_WAIT,
    AGU_GEN,
    AGU_DONE
  } fsm_bram_agu;

  localparam logic [1:0] AGU_IDX_BASE   = 2'd0;
  localparam logic [1:0] AGU_IDX_LEN    = 2'd1;
  localparam logic [1:0] AGU_IDX_STRIDE = 2'd2;

endpackage

// File: rtl/bram_cfg_agu_if.sv
// Handshake bundle between the interface controller / BRAM port and the
// address generator. The slave side is the generator itself.
interface bram_cfg_agu_if
  import bram_cfg_agu_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = 12
);
  FTk_t                  I_RCFG;
  logic                  I_Start;
  logic                  I_Abort;
  logic                  I_Stall;
  logic [WIDTH_ADDR-1:0] O_Addr;
  logic                  O_Addr_v;
  logic                  O_Last;
  logic                  O_Done;
  logic                  O_Busy;
  logic                  O_Err;

  modport master (
    output I_RCFG, I_Start, I_Abort, I_Stall,
    input  O_Addr, O_Addr_v, O_Last, O_Done, O_Busy, O_Err
  );

  modport slave (
    input  I_RCFG, I_Start, I_Abort, I_Stall,
    output O_Addr, O_Addr_v, O_Last, O_Done, O_Busy, O_Err
  );
endinterface

// File: rtl/bram_cfg_agu_step.sv
// Address / remaining-count datapath: load from configuration, then step by
// the stride once per accepted beat. Address arithmetic wraps modulo 2^WIDTH_ADDR.
module bram_cfg_agu_step #(
  parameter int unsigned WIDTH_ADDR = 12,
  parameter int unsigned WIDTH_LEN  = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [WIDTH_ADDR-1:0] i_base,
  input  logic [WIDTH_LEN-1:0]  i_len,
  input  logic [WIDTH_ADDR-1:0] i_stride,
  output logic [WIDTH_ADDR-1:0] o_addr,
  output logic [WIDTH_LEN-1:0]  o_remaining,
  output logic                  o_last
);
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH_LEN-1:0]  r_remaining;

  // Load has priority; otherwise advance one stride per accepted beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_base;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_addr      <= r_addr + i_stride;
      r_remaining <= r_remaining - WIDTH_LEN'(1);
    end
  end

  assign o_addr      = r_addr;
  assign o_remaining = r_remaining;
  assign o_last      = (r_remaining == WIDTH_LEN'(1));
endmodule

// File: rtl/bram_cfg_agu.sv
// BRAM configuration address generator: collects base/length/stride words,
// waits for a start request, then emits a strided address sequence under
// stall backpressure and pulses Done when the sequence completes.
module bram_cfg_agu
  import bram_cfg_agu_pkg::*;
#(
  parameter int unsigned WIDTH_ADDR = 12,
  parameter int unsigned WIDTH_LEN  = 12
) (
  input  logic          clock,
  input  logic          reset,
  bram_cfg_agu_if.slave bus
);
  fsm_bram_agu           r_state;
  logic [1:0]            r_idx;
  logic [WIDTH_ADDR-1:0] r_base;
  logic [WIDTH_LEN-1:0]  r_len;
  logic [WIDTH_ADDR-1:0] r_stride;
  logic                  r_err;

  logic                  w_load;
  logic                  w_step;
  logic [WIDTH_ADDR-1:0] w_addr;
  logic [WIDTH_LEN-1:0]  w_remaining;
  logic                  w_last;
  logic                  w_unused;

  // Abort must also freeze the datapath so an aborted final beat leaves no trace.
  assign w_load   = (r_state == AGU_WAIT) && bus.I_Start && !bus.I_Abort;
  assign w_step   = (r_state == AGU_GEN) && !bus.I_Stall && !bus.I_Abort;
  assign w_unused = ^{bus.I_RCFG.d, w_remaining};

  bram_cfg_agu_step #(
    .WIDTH_ADDR(WIDTH_ADDR),
    .WIDTH_LEN (WIDTH_LEN)
  ) u_step (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_base     (r_base),
    .i_len      (r_len),
    .i_stride   (r_stride),
    .o_addr     (w_addr),
    .o_remaining(w_remaining),
    .o_last     (w_last)
  );

  // Control FSM: config word capture, start, beat generation, abort and error pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= AGU_IDLE;
      r_idx    <= AGU_IDX_BASE;
      r_base   <= '0;
      r_len    <= '0;
      r_stride <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (bus.I_Abort) begin
        r_state <= AGU_IDLE;
        r_idx   <= AGU_IDX_BASE;
      end else begin
        case (r_state)
          AGU_IDLE: begin
            if (bus.I_RCFG.v) begin
              r_base  <= bus.I_RCFG.d[WIDTH_ADDR-1:0];
              r_idx   <= AGU_IDX_LEN;
              r_state <= AGU_CFG;
            end
          end
          AGU_CFG: begin
            if (bus.I_RCFG.v) begin
              if (r_idx == AGU_IDX_LEN) begin
                r_len <= bus.I_RCFG.d[WIDTH_LEN-1:0];
                r_idx <= AGU_IDX_STRIDE;
              end else begin
                r_stride <= bus.I_RCFG.d[WIDTH_ADDR-1:0];
                r_idx    <= AGU_IDX_BASE;
                r_state  <= AGU_WAIT;
              end
            end
          end
          AGU_WAIT: begin
            r_err <= bus.I_RCFG.v;
            if (bus.I_Start) begin
              r_state <= (r_len == '0) ? AGU_DONE : AGU_GEN;
            end
          end
          AGU_GEN: begin
            r_err <= bus.I_RCFG.v;
            if (!bus.I_Stall && w_last) begin
              r_state <= AGU_DONE;
            end
          end
          AGU_DONE: begin
            r_err   <= bus.I_RCFG.v;
            r_state <= AGU_IDLE;
          end
          default: r_state <= AGU_IDLE;
        endcase
      end
    end
  end

  assign bus.O_Addr   = w_addr;
  assign bus.O_Addr_v = (r_state == AGU_GEN);
  assign bus.O_Last   = (r_state == AGU_GEN) && w_last;
  assign bus.O_Done   = (r_state == AGU_DONE);
  assign bus.O_Busy   = (r_state != AGU_IDLE);
  assign bus.O_Err    = r_err;
endmodule

// File: tb/tb_bram_cfg_agu.sv
// Directed bench for bram_cfg_agu with an expected-beat scoreboard.
module tb_bram_cfg_agu;
  import bram_cfg_agu_pkg::*;

  localparam int unsigned WA = 12;
  localparam int unsigned WL = 12;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bram_cfg_agu_if #(.WIDTH_ADDR(WA)) bus ();

  bram_cfg_agu #(.WIDTH_ADDR(WA), .WIDTH_LEN(WL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [WA-1:0] addr;
    logic          last;
  } beat_t;

  beat_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int tick_no = 0;
  int exp_done_tick = -1;
  int done_cnt = 0;
  int err_cnt  = 0;
  int valid_cnt = 0;
  int d0, e0, v0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: retire the accepted beat at the edge, then check outputs at negedge.
  task automatic tick();
    logic acc;
    acc = bus.O_Addr_v && !bus.I_Stall;
    @(posedge clock);
    tick_no++;
    if (acc && q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0) exp_done_tick = tick_no;
    end
    @(negedge clock);
    if (bus.O_Addr_v) begin
      valid_cnt++;
      if (q.size() == 0) begin
        check("unexpected_addr_v", 32'(bus.O_Addr_v), 32'(0));
      end else begin
        check("addr", 32'(bus.O_Addr), 32'(q[0].addr));
        check("last", 32'(bus.O_Last), 32'(q[0].last));
      end
    end else begin
      check("last_without_valid", 32'(bus.O_Last), 32'(0));
    end
    if (bus.O_Done) begin
      done_cnt++;
      check("done_timing", 32'(tick_no), 32'(exp_done_tick));
    end
    if (bus.O_Err) err_cnt++;
  endtask

  task automatic send_cfg(input logic [WIDTH_DATA-1:0] b, input logic [WIDTH_DATA-1:0] l,
                          input logic [WIDTH_DATA-1:0] s);
    bus.I_RCFG.v = 1'b1;
    bus.I_RCFG.d = b; tick();
    bus.I_RCFG.d = l; tick();
    bus.I_RCFG.d = s; tick();
    bus.I_RCFG.v = 1'b0;
    bus.I_RCFG.d = '0;
  endtask

  task automatic push_seq(input logic [WA-1:0] base, input int unsigned len, input logic [WA-1:0] stride);
    logic [WA-1:0] a;
    a = base;
    for (int unsigned i = 0; i < len; i++) begin
      q.push_back(beat_t'{a, (i == len - 1)});
      a = a + stride;
    end
  endtask

  task automatic start();
    bus.I_Start = 1'b1;
    tick();
    bus.I_Start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.O_Busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(bus.O_Busy), 32'(0));
  endtask

  task automatic snap();
    d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt;
  endtask

  task automatic check_run(input string tag, input int nv, input int nd, input int ne);
    check({tag, "_queue"}, 32'(q.size()), 32'(0));
    check({tag, "_valid"}, 32'(valid_cnt - v0), 32'(nv));
    check({tag, "_done"},  32'(done_cnt - d0), 32'(nd));
    check({tag, "_err"},   32'(err_cnt - e0), 32'(ne));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at tick %0d", tick_no);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.I_RCFG  = '0;
    bus.I_Start = 1'b0;
    bus.I_Abort = 1'b0;
    bus.I_Stall = 1'b0;
    #1;
    check("rst_addr",   32'(bus.O_Addr),   32'(0));
    check("rst_addr_v", 32'(bus.O_Addr_v), 32'(0));
    check("rst_done",   32'(bus.O_Done),   32'(0));
    check("rst_busy",   32'(bus.O_Busy),   32'(0));
    check("rst_err",    32'(bus.O_Err),    32'(0));
    @(negedge clock);
    reset = 1'b1;

    // 1: basic sequence
    snap();
    send_cfg(16'h010, 16'd4, 16'd3);
    push_seq(12'h010, 4, 12'd3);
    start();
    wait_idle(20);
    check_run("s1", 4, 1, 0);

    // 2: three stall cycles on beat 2
    snap();
    send_cfg(16'h010, 16'd4, 16'd3);
    push_seq(12'h010, 4, 12'd3);
    start();
    tick();
    bus.I_Stall = 1'b1;
    tick(); tick(); tick();
    bus.I_Stall = 1'b0;
    wait_idle(20);
    check_run("s2", 7, 1, 0);

    // 3: address wrap
    snap();
    send_cfg(16'hFFE, 16'd3, 16'd1);
    push_seq(12'hFFE, 3, 12'd1);
    start();
    wait_idle(20);
    check_run("s3", 3, 1, 0);

    // 4: zero length
    snap();
    send_cfg(16'h100, 16'd0, 16'd5);
    exp_done_tick = tick_no + 1;
    start();
    check("len0_done", 32'(bus.O_Done), 32'(1));
    wait_idle(10);
    check_run("s4", 0, 1, 0);

    // 5: abort during beat 2, then a fresh configuration
    snap();
    send_cfg(16'h010, 16'd4, 16'd3);
    push_seq(12'h010, 4, 12'd3);
    start();
    tick();
    bus.I_Abort = 1'b1;
    tick();
    bus.I_Abort = 1'b0;
    check("abort_addr_v", 32'(bus.O_Addr_v), 32'(0));
    check("abort_busy",   32'(bus.O_Busy),   32'(0));
    q.delete();
    tick(); tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'(0));
    snap();
    send_cfg(16'h020, 16'd2, 16'd8);
    push_seq(12'h020, 2, 12'd8);
    start();
    wait_idle(20);
    check_run("s5", 2, 1, 0);

    // 6: stray config word during GEN
    snap();
    send_cfg(16'h010, 16'd4, 16'd3);
    push_seq(12'h010, 4, 12'd3);
    start();
    bus.I_RCFG.v = 1'b1;
    bus.I_RCFG.d = 16'h555;
    tick();
    bus.I_RCFG.v = 1'b0;
    bus.I_RCFG.d = '0;
    wait_idle(20);
    check_run("s6", 4, 1, 1);

    // 6b: asynchronous reset in the middle of GEN
    send_cfg(16'h010, 16'd4, 16'd3);
    push_seq(12'h010, 4, 12'd3);
    start();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_addr",   32'(bus.O_Addr),   32'(0));
    check("arst_addr_v", 32'(bus.O_Addr_v), 32'(0));
    check("arst_last",   32'(bus.O_Last),   32'(0));
    check("arst_done",   32'(bus.O_Done),   32'(0));
    check("arst_busy",   32'(bus.O_Busy),   32'(0));
    check("arst_err",    32'(bus.O_Err),    32'(0));
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus.O_Busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
